rd_resp_arbiter: RTL and testbench



---
 rtl/rd_resp_arbiter.sv | 114 +++++++++++
 tb/tb_rd_resp_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rd_resp_arbiter.sv
// Two-master read-response arbiter feeding a head-registered response FIFO.
// Define RESP_ARB_FIXED_PRIO_EN for fixed master-0 priority instead of round-robin.
module rd_resp_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  m0_resp,
    input  logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m0_resp_en,
    output logic                  m0_resp_ack,
    input  logic                  m1_resp,
    input  logic [DATA_WIDTH-1:0] m1_rdata,
    input  logic                  m1_resp_en,
    output logic                  m1_resp_ack,
    output logic                  s_resp,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_resp_src,
    input  logic                  s_resp_ready,
    output logic                  fifo_full
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] s_rdata_q;
    logic                  s_src_q;
    logic                  req0, req1, grant0, grant1;
    logic                  push, pop, empty, ptr_full, nonempty_d;
    logic [DATA_WIDTH:0]   push_data, head_d;
`ifndef RESP_ARB_FIXED_PRIO_EN
    logic                  last_grant_q;
`endif

    assign req0     = m0_resp & m0_resp_en;
    assign req1     = m1_resp & m1_resp_en;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign ptr_full = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                      (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);

    // A full buffer blocks grants even if the head pops this cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (aresetn && !ptr_full) begin
            if (req0 && req1) begin
`ifdef RESP_ARB_FIXED_PRIO_EN
                grant0 = 1'b1;
`else
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
`endif
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign m0_resp_ack = grant0;
    assign m1_resp_ack = grant1;
    assign push        = grant0 | grant1;
    assign pop         = !empty & s_resp_ready;
    assign push_data   = grant1 ? {1'b1, m1_rdata} : {1'b0, m0_rdata};

    assign wr_ptr_d   = wr_ptr_q + {{PTR_WIDTH{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{PTR_WIDTH{1'b0}}, pop};
    assign nonempty_d = (wr_ptr_d != rd_ptr_d);
    assign full_d     = (wr_ptr_d[PTR_WIDTH] != rd_ptr_d[PTR_WIDTH]) &&
                        (wr_ptr_d[PTR_WIDTH-1:0] == rd_ptr_d[PTR_WIDTH-1:0]);
    // When the next head slot is the one being written now, bypass the array.
    assign head_d     = (rd_ptr_d == wr_ptr_q) ? push_data : mem_q[rd_ptr_d[PTR_WIDTH-1:0]];

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= push_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            full_q    <= 1'b0;
            s_rdata_q <= '0;
            s_src_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            if (nonempty_d) begin
                s_rdata_q <= head_d[DATA_WIDTH-1:0];
                s_src_q   <= head_d[DATA_WIDTH];
            end
        end
    end

`ifndef RESP_ARB_FIXED_PRIO_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant_q <= 1'b1;
        end else if (push) begin
            last_grant_q <= grant1;
        end
    end
`endif

    assign s_resp     = !empty;
    assign s_rdata    = s_rdata_q;
    assign s_resp_src = s_src_q;
    assign fifo_full  = full_q;
endmodule

// File: tb/tb_rd_resp_arbiter.sv
// Directed + randomized bench for rd_resp_arbiter against a queue-based response model.
module tb_rd_resp_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          m0_resp, m0_resp_en, m0_resp_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_resp, m1_resp_en, m1_resp_ack;
    logic [DW-1:0] m1_rdata;
    logic          s_resp, s_resp_src, s_resp_ready, fifo_full;
    logic [DW-1:0] s_rdata;

    rd_resp_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m0_resp(m0_resp), .m0_rdata(m0_rdata), .m0_resp_en(m0_resp_en), .m0_resp_ack(m0_resp_ack),
        .m1_resp(m1_resp), .m1_rdata(m1_rdata), .m1_resp_en(m1_resp_en), .m1_resp_ack(m1_resp_ack),
        .s_resp(s_resp), .s_rdata(s_rdata), .s_resp_src(s_resp_src),
        .s_resp_ready(s_resp_ready), .fifo_full(fifo_full)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [DW:0] mq[$];
    bit          m_last = 1'b1;
    bit          exp_g0, exp_g1;
    int          dut_acks0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the reference model; called at posedge+1 after inputs are set.
    task automatic step();
        bit r0, r1, g0, g1, full, pop;
        #1;
        r0 = m0_resp && m0_resp_en;
        r1 = m1_resp && m1_resp_en;
        full = (mq.size() == DEPTH);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!full) begin
            if (r0 && r1) begin
`ifdef RESP_ARB_FIXED_PRIO_EN
                g0 = 1'b1;
`else
                if (m_last) g0 = 1'b1; else g1 = 1'b1;
`endif
            end else begin
                g0 = r0;
                g1 = r1;
            end
        end
        check("m0_ack", 32'(m0_resp_ack), 32'(g0));
        check("m1_ack", 32'(m1_resp_ack), 32'(g1));
        check("s_resp", 32'(s_resp), 32'(mq.size() != 0));
        check("fifo_full", 32'(fifo_full), 32'(full));
        if (mq.size() != 0) begin
            check("s_rdata", s_rdata, mq[0][DW-1:0]);
            check("s_resp_src", 32'(s_resp_src), 32'(mq[0][DW]));
        end
        if (m0_resp_ack) dut_acks0++;
        pop = (mq.size() != 0) && s_resp_ready;
        @(posedge aclk);
        if (pop) void'(mq.pop_front());
        if (g0) begin mq.push_back({1'b0, m0_rdata}); m_last = 1'b0; end
        if (g1) begin mq.push_back({1'b1, m1_rdata}); m_last = 1'b1; end
        exp_g0 = g0;
        exp_g1 = g1;
        #1;
    endtask

    initial begin
        int n0, n1;
        aresetn = 1'b0;
        m0_resp = 1'b1; m0_resp_en = 1'b1; m0_rdata = 32'h1;
        m1_resp = 1'b1; m1_resp_en = 1'b1; m1_rdata = 32'h2;
        s_resp_ready = 1'b0;
        #2;
        check("rst_m0_ack", 32'(m0_resp_ack), 32'd0);
        check("rst_m1_ack", 32'(m1_resp_ack), 32'd0);
        check("rst_s_resp", 32'(s_resp), 32'd0);
        check("rst_s_rdata", s_rdata, 32'd0);
        check("rst_src", 32'(s_resp_src), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        @(posedge aclk); #1;
        m0_resp = 1'b0; m1_resp = 1'b0;
        aresetn = 1'b1;

        // Single response from master 0, visible the next cycle.
        s_resp_ready = 1'b1;
        m0_resp = 1'b1; m0_rdata = 32'hA5A5_0001;
        step();
        m0_resp = 1'b0;
        step();
        step();

        // Master 1 not enabled: never acked until enable rises.
        m1_resp = 1'b1; m1_resp_en = 1'b0; m1_rdata = 32'h0000_BEEF;
        for (int i = 0; i < 5; i++) step();
        m1_resp_en = 1'b1;
        step();
        m1_resp = 1'b0;
        for (int i = 0; i < 2; i++) step();

        // Both masters contend; each holds its data until acked.
        n0 = 0; n1 = 0;
        m0_resp = 1'b1; m1_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_rdata = 32'h10 + n0;
            m1_rdata = 32'h20 + n1;
            step();
            if (exp_g0) n0++;
            if (exp_g1) n1++;
        end
        m0_resp = 1'b0; m1_resp = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Fill to full with the sink stalled, then release.
        s_resp_ready = 1'b0;
        dut_acks0 = 0;
        n0 = 0;
        m0_resp = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m0_rdata = 32'h30 + n0;
            step();
            if (exp_g0) n0++;
        end
        check("full_held_acks", 32'(dut_acks0), 32'd4);
        check("full_flag", 32'(fifo_full), 32'd1);
        s_resp_ready = 1'b1;
        for (int i = 0; i < 10 && n0 < 5; i++) begin
            m0_rdata = 32'h30 + n0;
            step();
            if (exp_g0) n0++;
        end
        check("fifth_acked", 32'(dut_acks0), 32'd5);
        m0_resp = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Steady push+pop at occupancy 1 across several pointer wraps.
        s_resp_ready = 1'b0;
        m0_resp = 1'b1; m0_rdata = 32'h40;
        step();
        s_resp_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            m0_rdata = 32'h40 + i;
            step();
        end
        m0_resp = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            m0_resp      = 1'($urandom_range(0, 1));
            m0_resp_en   = 1'($urandom_range(0, 3) != 0);
            m0_rdata     = $urandom;
            m1_resp      = 1'($urandom_range(0, 1));
            m1_resp_en   = 1'($urandom_range(0, 3) != 0);
            m1_rdata     = $urandom;
            s_resp_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end
        m0_resp = 1'b0; m1_resp = 1'b0; m0_resp_en = 1'b1; m1_resp_en = 1'b1;
        s_resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Reset mid-stream with three entries buffered and master 0 last granted.
        s_resp_ready = 1'b0;
        n0 = 0;
        m0_resp = 1'b1;
        for (int i = 0; i < 10 && n0 < 3; i++) begin
            m0_rdata = 32'h50 + n0;
            step();
            if (exp_g0) n0++;
        end
        m0_resp = 1'b0;
        step();
        check("pre_rst_s_resp", 32'(s_resp), 32'd1);
        m0_resp = 1'b1; m1_resp = 1'b1;
        m0_rdata = 32'h60; m1_rdata = 32'h70;
        aresetn = 1'b0;
        #1;
        check("mid_rst_s_resp", 32'(s_resp), 32'd0);
        check("mid_rst_m0_ack", 32'(m0_resp_ack), 32'd0);
        check("mid_rst_m1_ack", 32'(m1_resp_ack), 32'd0);
        @(posedge aclk); #1;
        check("mid_rst_full", 32'(fifo_full), 32'd0);
        aresetn = 1'b1;
        mq.delete();
        m_last = 1'b1;
        #1;
        check("post_rst_m0_wins", 32'(m0_resp_ack), 32'd1);
        check("post_rst_m1_idle", 32'(m1_resp_ack), 32'd0);
        step();
        m0_resp = 1'b0; m1_resp = 1'b0;
        s_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
